// File: rtl/platedetection_pkg.sv
// Shared types and constants for the plate-detection dilate controller.
//   state_e      : controller FSM states
//   BORDER_PIXEL : value driven for neighbours that fall outside the image
//                  (0 is neutral for a max-based dilation)
//   sat_inc32    : saturating 32-bit increment used by the optional
//                  frame-cycle statistics counter
`include "defines_platedetection.svh"

package platedetection_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN
  } state_e;

  localparam logic [`PIXEL_IN_WIDTH-1:0] BORDER_PIXEL = '0;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/defines_platedetection.svh
// Pixel bus widths shared by the plate-detection dilate controller, its
// package and anything that connects to it.
`ifndef DEFINES_PLATEDETECTION_SVH
`define DEFINES_PLATEDETECTION_SVH

`define PIXEL_IN_WIDTH  8
`define PIXEL_OUT_WIDTH 8

`endif

// File: rtl/line_buffer_platedetection.sv
// One-row line buffer for the dilate controller.
//   DEPTH entries of WIDTH bits, one write port and one synchronous read port.
//   A read and a write to the same address in one cycle return the old
//   contents (read-before-write). o_rdata holds its value while i_re is low.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset (read register only)
//   i_we/i_waddr/i_wdata: write port
//   i_re/i_raddr        : read request, data appears on o_rdata next cycle
//   o_rdata             : registered read data
module line_buffer_platedetection #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_d, rdata_q;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (i_re) rdata_d = mem[i_raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/dilate_ctrl_platedetection.sv
// Dilation window controller for plate detection.
// Streams a raster frame in, keeps two line buffers, and issues one 5-point
// cross window (up/down/left/right/center) per pixel to an external kernel.
// Kernel results are forwarded in raster order; o_frame_done pulses once all
// windows of the frame have returned.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_frame_start         : arms a frame when idle
//   i_pixel_valid/i_pixel : raster input, accepted when o_pixel_ready
//   o_start_kernel, o_pixel_{up,down,left,right,center} : window to kernel
//   i_end_kernel/i_pixel_dilate : kernel result strobe/data
//   o_result_valid/o_result     : registered kernel result
//   o_busy, o_frame_done        : status
//   o_frame_cycles              : only when DILATE_CTRL_STATS_EN is defined
`include "defines_platedetection.svh"

module dilate_ctrl_platedetection
  import platedetection_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_frame_start,
  input  logic                        i_pixel_valid,
  input  logic [`PIXEL_IN_WIDTH-1:0]  i_pixel,
  output logic                        o_pixel_ready,
  output logic                        o_start_kernel,
  output logic [`PIXEL_IN_WIDTH-1:0]  o_pixel_up,
  output logic [`PIXEL_IN_WIDTH-1:0]  o_pixel_down,
  output logic [`PIXEL_IN_WIDTH-1:0]  o_pixel_left,
  output logic [`PIXEL_IN_WIDTH-1:0]  o_pixel_right,
  output logic [`PIXEL_IN_WIDTH-1:0]  o_pixel_center,
  input  logic                        i_end_kernel,
  input  logic [`PIXEL_OUT_WIDTH-1:0] i_pixel_dilate,
  output logic                        o_result_valid,
  output logic [`PIXEL_OUT_WIDTH-1:0] o_result,
  output logic                        o_busy,
  output logic                        o_frame_done
`ifdef DILATE_CTRL_STATS_EN
  ,
  output logic [31:0]                 o_frame_cycles
`endif
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);
  localparam int unsigned OW = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);
  localparam int unsigned PW = `PIXEL_IN_WIDTH;

  state_e state_q, state_d;

  logic [CW-1:0] col_q, col_d, win_col_q, win_col_d;
  logic [RW-1:0] row_q, row_d, win_row_q, win_row_d;
  logic [PW-1:0] center_q, center_d, left_q, left_d, down_q, down_d;
  logic          start_q, start_d;
  logic [OW-1:0] outst_q, outst_d;
  logic          frame_done_q, frame_done_d;
  logic          result_valid_q;
  logic [`PIXEL_OUT_WIDTH-1:0] result_q;

  logic          accept, flush_step, step, win_step;
  logic          col_last, row_last;
  logic [CW-1:0] col_next;
  logic [PW-1:0] cur_rdata, prev_rdata;

  assign accept     = i_pixel_valid & o_pixel_ready;
  assign flush_step = (state_q == ST_FLUSH);
  assign step       = accept | flush_step;
  assign win_step   = (accept && state_q == ST_RUN) || flush_step;
  assign col_last   = (col_q == CW'(IMG_WIDTH - 1));
  assign row_last   = (row_q == RW'(IMG_HEIGHT - 1));
  assign col_next   = col_last ? '0 : col_q + CW'(1);

  // Current-row buffer is read one column ahead of the write, so the read
  // delivers the right neighbour; at the end of a row it wraps to column 0
  // and prefetches the first pixel of the row just written (next centre).
  line_buffer_platedetection #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PW),
    .AW    (CW)
  ) u_lb_cur (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (accept),
    .i_waddr (col_q),
    .i_wdata (i_pixel),
    .i_re    (step),
    .i_raddr (col_next),
    .o_rdata (cur_rdata)
  );

  // Previous-row buffer: the held centre (row r) replaces row r-1 at the same
  // column, read-before-write yields the up neighbour.
  line_buffer_platedetection #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PW),
    .AW    (CW)
  ) u_lb_prev (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (accept && state_q == ST_RUN),
    .i_waddr (col_q),
    .i_wdata (cur_rdata),
    .i_re    (step),
    .i_raddr (col_q),
    .o_rdata (prev_rdata)
  );

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      col_q          <= '0;
      row_q          <= '0;
      win_col_q      <= '0;
      win_row_q      <= '0;
      center_q       <= '0;
      left_q         <= '0;
      down_q         <= '0;
      start_q        <= 1'b0;
      outst_q        <= '0;
      frame_done_q   <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      win_col_q      <= win_col_d;
      win_row_q      <= win_row_d;
      center_q       <= center_d;
      left_q         <= left_d;
      down_q         <= down_d;
      start_q        <= start_d;
      outst_q        <= outst_d;
      frame_done_q   <= frame_done_d;
      result_valid_q <= i_end_kernel;
      result_q       <= i_pixel_dilate;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_frame_start)                   state_d = ST_FILL;
      ST_FILL:  if (accept && col_last)              state_d = ST_RUN;
      ST_RUN:   if (accept && col_last && row_last)  state_d = ST_FLUSH;
      ST_FLUSH: if (col_last)                        state_d = ST_DRAIN;
      ST_DRAIN: if (outst_q == '0 && !start_q)       state_d = ST_IDLE;
      default:                                       state_d = ST_IDLE;
    endcase
  end

  // Counters, window pipeline and outstanding-window tracking
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    win_col_d = win_col_q;
    win_row_d = win_row_q;
    center_d  = center_q;
    left_d    = left_q;
    down_d    = down_q;
    start_d   = win_step;
    outst_d   = outst_q;

    if (state_q == ST_IDLE) begin
      col_d = '0;
      row_d = '0;
    end else if (step) begin
      col_d = col_next;
      if (col_last && !flush_step) row_d = row_last ? '0 : row_q + RW'(1);
      center_d  = cur_rdata;
      left_d    = center_q;
      down_d    = flush_step ? BORDER_PIXEL : i_pixel;
      win_col_d = col_q;
      win_row_d = flush_step ? RW'(IMG_HEIGHT - 1) : row_q - RW'(1);
    end

    case ({start_q, i_end_kernel})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    frame_done_d = (state_q == ST_DRAIN) && (state_d == ST_IDLE);
  end

  // Output logic
  always_comb begin
    o_pixel_ready  = (state_q == ST_FILL) || (state_q == ST_RUN);
    o_busy         = (state_q != ST_IDLE);
    o_start_kernel = start_q;
    o_pixel_center = BORDER_PIXEL;
    o_pixel_left   = BORDER_PIXEL;
    o_pixel_right  = BORDER_PIXEL;
    o_pixel_up     = BORDER_PIXEL;
    o_pixel_down   = BORDER_PIXEL;
    if (start_q) begin
      o_pixel_center = center_q;
      o_pixel_down   = down_q;
      o_pixel_left   = (win_col_q == '0)                  ? BORDER_PIXEL : left_q;
      o_pixel_right  = (win_col_q == CW'(IMG_WIDTH - 1))  ? BORDER_PIXEL : cur_rdata;
      o_pixel_up     = (win_row_q == '0)                  ? BORDER_PIXEL : prev_rdata;
    end
  end

  assign o_result_valid = result_valid_q;
  assign o_result       = result_q;
  assign o_frame_done   = frame_done_q;

`ifdef DILATE_CTRL_STATS_EN
  logic [31:0] cyc_q, cyc_d, fcyc_q, fcyc_d;

  // The start-accept cycle counts as 1; the captured value is the distance
  // from start acceptance to the cycle o_frame_done is high.
  always_comb begin
    cyc_d  = cyc_q;
    fcyc_d = fcyc_q;
    if (state_q == ST_IDLE) begin
      if (i_frame_start) cyc_d = 32'd1;
    end else begin
      cyc_d = sat_inc32(cyc_q);
    end
    if (frame_done_d) fcyc_d = sat_inc32(cyc_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      fcyc_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      fcyc_q <= fcyc_d;
    end
  end

  assign o_frame_cycles = fcyc_q;
`endif

endmodule
